// File: rtl/pwm_duty_sequencer.sv
// pwm_duty_sequencer: PWM tick/period timing plus duty sequencing in MANUAL and BREATHE modes
module pwm_duty_sequencer #(
    parameter int DUTY_W           = 8,
    parameter int PRESCALE_BITS    = 7,
    parameter int STEP             = 5,
    parameter int PERIODS_PER_STEP = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              up_req,
    input  logic              dn_req,
    input  logic              mode_toggle,
    output logic              pwm_tick,
    output logic              period_start,
    output logic [DUTY_W-1:0] duty,
    output logic [DUTY_W-1:0] target,
    output logic              breathing
);
    localparam int SC_W = PERIODS_PER_STEP > 1 ? $clog2(PERIODS_PER_STEP) : 1;
    localparam logic [DUTY_W:0]   STEP_X  = (DUTY_W+1)'(STEP);
    localparam logic [DUTY_W-1:0] MAX     = '1;
    localparam logic [SC_W-1:0]   SC_LAST = SC_W'(PERIODS_PER_STEP - 1);

    typedef enum logic [1:0] {MANUAL, BREATHE_UP, BREATHE_DOWN} state_t;

    state_t                   state;
    logic [PRESCALE_BITS-1:0] prescaler;
    logic [DUTY_W-1:0]        period_cnt;
    logic [SC_W-1:0]          step_cnt;
    logic [DUTY_W:0]          sum;
    logic [DUTY_W:0]          diff;
    logic [DUTY_W-1:0]        sat_up;
    logic [DUTY_W-1:0]        sat_dn;
    logic                     do_step;

    assign pwm_tick     = &prescaler;
    assign period_start = pwm_tick && (&period_cnt);

    // One-bit-wider arithmetic: the carry/borrow bit selects the saturation value
    always_comb begin
        sum     = {1'b0, target} + STEP_X;
        diff    = {1'b0, target} - STEP_X;
        sat_up  = sum[DUTY_W] ? MAX : sum[DUTY_W-1:0];
        sat_dn  = diff[DUTY_W] ? '0 : diff[DUTY_W-1:0];
        do_step = (state != MANUAL) && period_start && (step_cnt == SC_LAST);
    end

    // Free-running prescaler and PWM period counter
    always_ff @(posedge CLK) begin
        if (RST) begin
            prescaler  <= '0;
            period_cnt <= '0;
        end else begin
            prescaler <= prescaler + 1'b1;
            if (pwm_tick)
                period_cnt <= period_cnt + 1'b1;
        end
    end

    // Mode FSM; target moves freely, duty only takes target at period boundaries
    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= MANUAL;
            breathing <= 1'b0;
            target    <= '0;
            duty      <= '0;
            step_cnt  <= '0;
        end else begin
            if (period_start)
                duty <= target;
            if (state == MANUAL) begin
                if (up_req && !dn_req)
                    target <= sat_up;
                else if (dn_req && !up_req)
                    target <= sat_dn;
                if (mode_toggle) begin
                    state     <= BREATHE_UP;
                    breathing <= 1'b1;
                    step_cnt  <= '0;
                end
            end else begin
                if (period_start)
                    step_cnt <= (step_cnt == SC_LAST) ? '0 : step_cnt + 1'b1;
                if (do_step)
                    target <= (state == BREATHE_UP) ? sat_up : sat_dn;
                if (mode_toggle) begin
                    state     <= MANUAL;
                    breathing <= 1'b0;
                end else if (do_step && state == BREATHE_UP && sat_up == MAX)
                    state <= BREATHE_DOWN;
                else if (do_step && state == BREATHE_DOWN && sat_dn == '0)
                    state <= BREATHE_UP;
            end
        end
    end
endmodule
